// File: rtl/hex_scan_scheduler.sv
// ============================================================================
// Module      : hex_scan_scheduler
// Description : Multiplexes NUM_DIGITS nibbles onto one shared hex decoder and
//               segment bus, committing new display data only at frame ends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_scan_scheduler #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_blank,
   output logic [3:0]              dec_in,
   input  logic [6:0]              dec_out,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {
      ST_GUARD = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [3:0]              dec_in_q, dec_in_d;
   logic [6:0]              seg_q, seg_d;
   logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
   logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
   logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                    pend_full_q, pend_full_d;

   logic                    w_last_show;
   logic                    w_last_digit;
   logic [3:0]              w_cur_nibble;
   logic                    w_cur_blank;

   assign w_last_show  = (state_q == ST_SHOW) && (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign w_last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign w_cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];
   assign w_cur_blank  = act_blank_q[idx_q];

   assign frame_done = w_last_show && w_last_digit;
   assign load_ready = !pend_full_q;
   assign dec_in     = dec_in_q;
   assign seg        = seg_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      dec_in_d     = dec_in_q;
      seg_d        = seg_q;
      act_data_d   = act_data_q;
      act_blank_d  = act_blank_q;
      pend_data_d  = pend_data_q;
      pend_blank_d = pend_blank_q;
      pend_full_d  = pend_full_q;
      digit_en     = '1;

      case (state_q)
         ST_GUARD: begin
            dec_in_d = w_cur_nibble;
            seg_d    = 7'h7F;
            state_d  = ST_FETCH;
         end
         ST_FETCH: begin
            seg_d   = w_cur_blank ? 7'h7F : dec_out;
            cnt_d   = '0;
            state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (!w_cur_blank) begin
               digit_en[idx_q] = 1'b0;
            end
            if (w_last_show) begin
               cnt_d   = '0;
               seg_d   = 7'h7F;
               idx_d   = w_last_digit ? '0 : idx_q + IDX_W'(1);
               state_d = ST_GUARD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_GUARD;
      endcase

      // Capture and commit are mutually exclusive: capture needs pending empty.
      if (load_valid && !pend_full_q) begin
         pend_data_d  = load_data;
         pend_blank_d = load_blank;
         pend_full_d  = 1'b1;
      end else if (frame_done && pend_full_q) begin
         act_data_d  = pend_data_q;
         act_blank_d = pend_blank_q;
         pend_full_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_GUARD;
         idx_q        <= '0;
         cnt_q        <= '0;
         dec_in_q     <= '0;
         seg_q        <= 7'h7F;
         act_data_q   <= '0;
         act_blank_q  <= '0;
         pend_data_q  <= '0;
         pend_blank_q <= '0;
         pend_full_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         dec_in_q     <= dec_in_d;
         seg_q        <= seg_d;
         act_data_q   <= act_data_d;
         act_blank_q  <= act_blank_d;
         pend_data_q  <= pend_data_d;
         pend_blank_q <= pend_blank_d;
         pend_full_q  <= pend_full_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hex_scan_scheduler.sv
// ============================================================================
// Module      : tb_hex_scan_scheduler
// Description : Directed self-checking bench for hex_scan_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_scan_scheduler;

   localparam int NUM_DIGITS  = 4;
   localparam int REFRESH_DIV = 4;
   localparam int CNT_W       = 16;

   logic        clock;
   logic        resetn;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  load_blank;
   logic [3:0]  dec_in;
   logic [6:0]  dec_out;
   logic [6:0]  seg;
   logic [3:0]  digit_en;
   logic        frame_done;

   int passed;
   int total;
   int cyc;

   hex_scan_scheduler #(
      .NUM_DIGITS (NUM_DIGITS),
      .REFRESH_DIV(REFRESH_DIV),
      .CNT_W      (CNT_W)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .load_blank(load_blank),
      .dec_in    (dec_in),
      .dec_out   (dec_out),
      .seg       (seg),
      .digit_en  (digit_en),
      .frame_done(frame_done)
   );

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   assign dec_out = hex7(dec_in);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
   endtask

   task automatic reset_checks();
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_digit_en", {28'd0, digit_en}, 32'hF);
      check("rst_dec_in", {28'd0, dec_in}, 32'h0);
      check("rst_frame_done", {31'd0, frame_done}, 32'h0);
      check("rst_load_ready", {31'd0, load_ready}, 32'h1);
   endtask

   // Cycle-by-cycle expectation for a frame-aligned scan (period 6, frame 24).
   task automatic run_cycles(input int n, input logic [15:0] data,
                             input logic [3:0] blank, input logic rdy);
      for (int k = 0; k < n; k++) begin
         int         ph;
         int         d;
         logic [3:0] nib;
         logic [3:0] exp_en;
         logic [6:0] exp_seg;
         ph      = cyc % 6;
         d       = (cyc / 6) % 4;
         nib     = data[d*4 +: 4];
         exp_en  = 4'hF;
         exp_seg = 7'h7F;
         if (ph >= 2 && !blank[d]) begin
            exp_en[d] = 1'b0;
            exp_seg   = hex7(nib);
         end
         check("digit_en", {28'd0, digit_en}, {28'd0, exp_en});
         check("seg", {25'd0, seg}, {25'd0, exp_seg});
         check("frame_done", {31'd0, frame_done}, {31'd0, (d == 3 && ph == 5)});
         check("load_ready", {31'd0, load_ready}, {31'd0, rdy});
         if (ph >= 1) check("dec_in", {28'd0, dec_in}, {28'd0, nib});
         @(negedge clock);
         cyc = cyc + 1;
      end
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      cyc        = 0;
      resetn     = 1'b0;
      load_valid = 1'b0;
      load_data  = 16'h0;
      load_blank = 4'h0;

      repeat (3) @(negedge clock);
      reset_checks();

      resetn = 1'b1;
      cyc    = 0;
      run_cycles(5, 16'h0000, 4'h0, 1'b1);
      load_valid = 1'b1; load_data = 16'h1234; load_blank = 4'h0;
      run_cycles(1, 16'h0000, 4'h0, 1'b1);
      // Held request while pending is full must wait for the commit.
      load_data = 16'h5678;
      run_cycles(18, 16'h0000, 4'h0, 1'b0);
      run_cycles(1, 16'h1234, 4'h0, 1'b1);
      load_valid = 1'b0;
      run_cycles(23, 16'h1234, 4'h0, 1'b0);
      run_cycles(24, 16'h5678, 4'h0, 1'b1);

      load_valid = 1'b1; load_data = 16'h1234; load_blank = 4'b0010;
      run_cycles(1, 16'h5678, 4'h0, 1'b1);
      load_valid = 1'b0;
      run_cycles(23, 16'h5678, 4'h0, 1'b0);
      run_cycles(24, 16'h1234, 4'b0010, 1'b1);

      load_valid = 1'b1; load_data = 16'h9ABC; load_blank = 4'h0;
      run_cycles(1, 16'h1234, 4'b0010, 1'b1);
      load_valid = 1'b0;
      run_cycles(15, 16'h1234, 4'b0010, 1'b0);

      // Mid-SHOW of digit 2 with pending full.
      resetn = 1'b0;
      #1;
      reset_checks();
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      cyc    = 0;
      run_cycles(24, 16'h0000, 4'h0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
